// File: rtl/s2mm_pkg.sv
// Shared command/status types and helpers for the S2MM command sequencer.
package s2mm_pkg;

   typedef struct packed {
      logic [3:0]  rsvd;
      logic [3:0]  tag;
      logic [31:0] saddr;
      logic [7:0]  drr_eof;
      logic        incr;
      logic [22:0] btt;
   } s2mm_cmd_t;

   typedef struct packed {
      logic       okay;
      logic       slverr;
      logic       decerr;
      logic       interr;
      logic [3:0] tag;
   } s2mm_sts_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2
   } seq_state_t;

   function automatic s2mm_cmd_t pack_cmd(input logic [3:0]  tag,
                                          input logic [31:0] saddr,
                                          input logic [22:0] btt);
      s2mm_cmd_t cmd;
      cmd.rsvd    = 4'h0;
      cmd.tag     = tag;
      cmd.saddr   = saddr;
      cmd.drr_eof = 8'h00;
      cmd.incr    = 1'b1;
      cmd.btt     = btt;
      return cmd;
   endfunction

   // A status completes a block only if it is OKAY with no error flag and carries the awaited tag.
   function automatic logic sts_clean(input s2mm_sts_t sts, input logic [3:0] exp_tag);
      return sts.okay & ~sts.slverr & ~sts.decerr & ~sts.interr & (sts.tag == exp_tag);
   endfunction

endpackage

// File: rtl/ring_addr_gen.sv
// Ring-buffer address generator: advances by STEP on inc and folds back to BASE at BASE+SIZE.
module ring_addr_gen #(
   parameter logic [31:0] BASE = 32'h0000_0000,
   parameter logic [31:0] SIZE = 32'h0010_0000,
   parameter logic [31:0] STEP = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   output logic [31:0] addr
);

   localparam logic [31:0] RING_END = BASE + SIZE;

   logic [31:0] addr_r;
   logic [31:0] next_s;

   // Next address with wrap at the end of the ring.
   always_comb begin
      if ((addr_r + STEP) == RING_END) begin
         next_s = BASE;
      end else begin
         next_s = addr_r + STEP;
      end
   end

   // Address register.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r <= BASE;
      end else if (inc) begin
         addr_r <= next_s;
      end
   end

   assign addr = addr_r;

endmodule

// File: rtl/s2mm_cmd_sequencer.sv
// S2MM command sequencer: streams fixed-size INCR commands into a DDR ring buffer
// and checks DataMover status to publish the completed-write pointer.
module s2mm_cmd_sequencer
   import s2mm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter logic [31:0] BUF_BYTES       = 32'h0010_0000,
   parameter logic [22:0] BTT             = 23'h00_1000,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [71:0] cmd_tdata,
   output logic        cmd_tvalid,
   input  logic        cmd_tready,
   input  logic [7:0]  sts_tdata,
   input  logic        sts_tvalid,
   output logic        sts_tready,
   output logic [31:0] wr_ptr,
   output logic [31:0] blocks_done,
   output logic [3:0]  outstanding,
   output logic        busy,
   output logic        err,
   output logic [7:0]  err_sts
);

   localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
   localparam logic [31:0] STEP    = {9'h000, BTT};

   seq_state_t  state_r, state_s;
   logic        cmd_tvalid_r, cmd_tvalid_s;
   logic        sts_tready_r;
   logic [3:0]  tag_r, exp_tag_r;
   logic [3:0]  outstanding_r, outstanding_s;
   logic [31:0] blocks_done_r;
   logic        err_r;
   logic [7:0]  err_sts_r;
   logic        busy_r;
   logic [31:0] issue_addr_s;
   logic        cmd_hs_s, sts_hs_s, sts_dec_s, sts_ok_s, err_set_s, err_any_s;

   assign cmd_hs_s  = cmd_tvalid_r & cmd_tready;
   assign sts_hs_s  = sts_tvalid & sts_tready_r;
   assign sts_dec_s = sts_hs_s & (outstanding_r != 4'd0);
   // After a halt, statuses are drained but no longer move the pointer or raise a new error.
   assign sts_ok_s  = sts_dec_s & ~err_r & sts_clean(s2mm_sts_t'(sts_tdata), exp_tag_r);
   assign err_set_s = sts_hs_s & ~err_r & ~sts_ok_s;
   assign err_any_s = err_r | err_set_s;

   ring_addr_gen #(.BASE(BASE_ADDR), .SIZE(BUF_BYTES), .STEP(STEP)) u_issue_addr (
      .clk   (clk),
      .reset (reset),
      .inc   (cmd_hs_s),
      .addr  (issue_addr_s)
   );

   ring_addr_gen #(.BASE(BASE_ADDR), .SIZE(BUF_BYTES), .STEP(STEP)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (sts_ok_s),
      .addr  (wr_ptr)
   );

   // Next state and command valid; an asserted tvalid is only ever dropped by a handshake.
   always_comb begin
      state_s      = state_r;
      cmd_tvalid_s = cmd_tvalid_r;
      case (state_r)
         IDLE: begin
            if (err_any_s) begin
               state_s = HALT;
            end else if (enable && (outstanding_r < MAX_OUT)) begin
               state_s      = ISSUE;
               cmd_tvalid_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            cmd_tvalid_s = ~cmd_hs_s;
            if (err_any_s) begin
               state_s = HALT;
            end else if (cmd_hs_s) begin
               state_s = IDLE;
            end else begin
               state_s = ISSUE;
            end
         end
         HALT: begin
            state_s      = HALT;
            cmd_tvalid_s = cmd_tvalid_r & ~cmd_hs_s;
         end
         default: begin
            state_s      = HALT;
            cmd_tvalid_s = 1'b0;
         end
      endcase
   end

   // In-flight count; simultaneous issue and completion cancel out.
   always_comb begin
      if (cmd_hs_s && !sts_dec_s) begin
         outstanding_s = outstanding_r + 4'd1;
      end else if (!cmd_hs_s && sts_dec_s) begin
         outstanding_s = outstanding_r - 4'd1;
      end else begin
         outstanding_s = outstanding_r;
      end
   end

   // Sequencer state, counters and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         cmd_tvalid_r  <= 1'b0;
         sts_tready_r  <= 1'b0;
         tag_r         <= 4'd0;
         exp_tag_r     <= 4'd0;
         outstanding_r <= 4'd0;
         blocks_done_r <= 32'd0;
         err_r         <= 1'b0;
         err_sts_r     <= 8'h00;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         cmd_tvalid_r  <= cmd_tvalid_s;
         sts_tready_r  <= 1'b1;
         outstanding_r <= outstanding_s;
         busy_r        <= (outstanding_s != 4'd0) | cmd_tvalid_s;
         if (cmd_hs_s) begin
            tag_r <= tag_r + 4'd1;
         end
         if (sts_ok_s) begin
            exp_tag_r     <= exp_tag_r + 4'd1;
            blocks_done_r <= blocks_done_r + 32'd1;
         end
         if (err_set_s) begin
            err_r     <= 1'b1;
            err_sts_r <= sts_tdata;
         end
      end
   end

   assign cmd_tdata   = pack_cmd(tag_r, issue_addr_s, BTT);
   assign cmd_tvalid  = cmd_tvalid_r;
   assign sts_tready  = sts_tready_r;
   assign blocks_done = blocks_done_r;
   assign outstanding = outstanding_r;
   assign busy        = busy_r;
   assign err         = err_r;
   assign err_sts     = err_sts_r;

endmodule

// File: tb/tb_s2mm_cmd_sequencer.sv
// Self-checking bench for s2mm_cmd_sequencer with a DataMover model returning statuses
// after a configurable latency and an arithmetic reference for addresses and tags.
module tb_s2mm_cmd_sequencer;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] BUF   = 32'h0000_4000;
   localparam logic [22:0] BTT23 = 23'h00_1000;
   localparam logic [31:0] BTTB  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [71:0] cmd_tdata;
   logic        cmd_tvalid;
   logic        cmd_tready = 1'b0;
   logic [7:0]  sts_tdata;
   logic        sts_tvalid;
   logic        sts_tready;
   logic [31:0] wr_ptr;
   logic [31:0] blocks_done;
   logic [3:0]  outstanding;
   logic        busy;
   logic        err;
   logic [7:0]  err_sts;

   s2mm_cmd_sequencer #(
      .BASE_ADDR(BASE), .BUF_BYTES(BUF), .BTT(BTT23), .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
      .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
      .wr_ptr(wr_ptr), .blocks_done(blocks_done), .outstanding(outstanding),
      .busy(busy), .err(err), .err_sts(err_sts)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;

   // DataMover model controls (written by tests only)
   bit         auto_sts = 1'b1;
   int         lat_min = 20;
   int         lat_max = 20;
   int         corrupt_idx = -1;
   logic [7:0] corrupt_word = 8'h00;
   int         force_seq = 0;
   logic [7:0] force_word = 8'h00;

   // DataMover model state (written by the model only)
   logic [71:0] cmd_log[$];
   logic [7:0]  pend_word[$];
   int          pend_due[$];
   int          cyc = 0;
   int          force_ack = 0;
   logic [3:0]  max_out = 4'd0;

   // Reference: the idx-th command after reset, from the ring arithmetic.
   function automatic logic [71:0] exp_cmd(input int idx);
      logic [31:0] a;
      logic [31:0] i32;
      i32 = 32'(idx);
      a = BASE + ((i32 * BTTB) % BUF);
      return {4'h0, i32[3:0], a, 8'h00, 1'b1, BTT23};
   endfunction

   function automatic logic [31:0] exp_ptr(input int n);
      return BASE + ((32'(n) * BTTB) % BUF);
   endfunction

   initial begin : dm_model
      bit c_hs, s_hs, r_seen;
      sts_tvalid = 1'b0;
      sts_tdata  = 8'h00;
      forever begin
         @(negedge clk);
         c_hs   = cmd_tvalid && cmd_tready;
         s_hs   = sts_tvalid && sts_tready;
         r_seen = reset;
         if (!reset && outstanding > max_out) max_out = outstanding;
         if (c_hs) begin
            if (auto_sts) begin
               if (cmd_log.size() == corrupt_idx) pend_word.push_back(corrupt_word);
               else pend_word.push_back({4'h8, cmd_tdata[67:64]});
               pend_due.push_back(cyc + lat_min + int'($urandom_range(lat_max - lat_min, 0)));
            end
            cmd_log.push_back(cmd_tdata);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (r_seen) begin
            pend_word.delete();
            pend_due.delete();
            cmd_log.delete();
            max_out    = 4'd0;
            sts_tvalid = 1'b0;
            force_ack  = force_seq;
         end else begin
            if (s_hs) sts_tvalid = 1'b0;
            if (!sts_tvalid) begin
               if (force_seq != force_ack) begin
                  sts_tdata  = force_word;
                  sts_tvalid = 1'b1;
                  force_ack  = force_seq;
               end else if (pend_word.size() != 0 && pend_due[0] <= cyc) begin
                  sts_tdata  = pend_word.pop_front();
                  void'(pend_due.pop_front());
                  sts_tvalid = 1'b1;
               end
            end
         end
      end
   end

   task automatic apply_reset();
      reset       = 1'b1;
      enable      = 1'b0;
      cmd_tready  = 1'b0;
      auto_sts    = 1'b1;
      corrupt_idx = -1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (cmd_tvalid !== 1'b0) $display("FAIL reset_cmd_tvalid: got %b want 0", cmd_tvalid); else n_pass++;
      n_checks++; if (sts_tready !== 1'b0) $display("FAIL reset_sts_tready: got %b want 0", sts_tready); else n_pass++;
      n_checks++; if (wr_ptr !== BASE) $display("FAIL reset_wr_ptr: got %h want %h", wr_ptr, BASE); else n_pass++;
      n_checks++; if (blocks_done !== 32'd0) $display("FAIL reset_blocks_done: got %0d want 0", blocks_done); else n_pass++;
      n_checks++; if (outstanding !== 4'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding); else n_pass++;
      n_checks++; if (err !== 1'b0 || err_sts !== 8'h00) $display("FAIL reset_err: got %b/%h want 0/00", err, err_sts); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (sts_tready !== 1'b1 || cmd_tvalid !== 1'b0) $display("FAIL post_reset_ready: got %b/%b want 1/0", sts_tready, cmd_tvalid); else n_pass++;
   endtask

   task automatic test_stream_wrap();
      int n;
      apply_reset();
      lat_min = 20; lat_max = 20;
      enable = 1'b1; cmd_tready = 1'b1;
      for (int k = 0; k < 200 && blocks_done !== 32'd4; k++) @(negedge clk);
      n_checks++; if (blocks_done !== 32'd4 || wr_ptr !== BASE) $display("FAIL wrap_wr_ptr: got %0d/%h want 4/%h", blocks_done, wr_ptr, BASE); else n_pass++;
      for (int k = 0; k < 300 && cmd_log.size() < 10; k++) @(negedge clk);
      @(posedge clk);
      #1;
      enable = 1'b0;
      for (int k = 0; k < 300 && busy !== 1'b0; k++) @(negedge clk);
      n = cmd_log.size();
      n_checks++; if (n < 10) $display("FAIL stream_count: got %0d want >=10", n); else n_pass++;
      for (int i = 0; i < n; i++) begin
         n_checks++; if (cmd_log[i] !== exp_cmd(i)) $display("FAIL stream_cmd%0d: got %h want %h", i, cmd_log[i], exp_cmd(i)); else n_pass++;
      end
      n_checks++; if (max_out !== 4'd4) $display("FAIL stream_max_out: got %0d want 4", max_out); else n_pass++;
      n_checks++; if (blocks_done !== 32'(n) || wr_ptr !== exp_ptr(n)) $display("FAIL stream_done: got %0d/%h want %0d/%h", blocks_done, wr_ptr, n, exp_ptr(n)); else n_pass++;
      n_checks++; if (busy !== 1'b0 || outstanding !== 4'd0 || err !== 1'b0) $display("FAIL stream_idle: got busy=%b out=%0d err=%b want 0/0/0", busy, outstanding, err); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [71:0] first;
      int bad = 0;
      apply_reset();
      lat_min = 5; lat_max = 5;
      enable = 1'b1; cmd_tready = 1'b0;
      for (int k = 0; k < 20 && cmd_tvalid !== 1'b1; k++) @(negedge clk);
      first = cmd_tdata;
      n_checks++; if (first !== exp_cmd(0)) $display("FAIL bp_first_cmd: got %h want %h", first, exp_cmd(0)); else n_pass++;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) enable = 1'b0;
         @(negedge clk);
         if (cmd_tvalid !== 1'b1 || cmd_tdata !== first) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else n_pass++;
      @(posedge clk);
      #1;
      cmd_tready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1 || outstanding !== 4'd1 || cmd_tvalid !== 1'b0) $display("FAIL bp_accepted: got busy=%b out=%0d tvalid=%b want 1/1/0", busy, outstanding, cmd_tvalid); else n_pass++;
      for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
      n_checks++; if (busy !== 1'b0 || blocks_done !== 32'd1 || wr_ptr !== exp_ptr(1)) $display("FAIL bp_drain: got busy=%b done=%0d ptr=%h want 0/1/%h", busy, blocks_done, wr_ptr, exp_ptr(1)); else n_pass++;
      repeat (30) @(negedge clk);
      n_checks++; if (cmd_log.size() != 1) $display("FAIL bp_no_more_cmds: got %0d want 1", cmd_log.size()); else n_pass++;
   endtask

   task automatic test_slverr();
      int n_at_err;
      apply_reset();
      lat_min = 20; lat_max = 20;
      corrupt_idx = 2; corrupt_word = 8'hC2;
      enable = 1'b1; cmd_tready = 1'b1;
      for (int k = 0; k < 200 && err !== 1'b1; k++) @(negedge clk);
      n_checks++; if (err !== 1'b1 || err_sts !== 8'hC2) $display("FAIL slverr_flag: got %b/%h want 1/c2", err, err_sts); else n_pass++;
      n_checks++; if (blocks_done !== 32'd2 || wr_ptr !== exp_ptr(2)) $display("FAIL slverr_done: got %0d/%h want 2/%h", blocks_done, wr_ptr, exp_ptr(2)); else n_pass++;
      n_at_err = cmd_log.size();
      for (int k = 0; k < 200 && busy !== 1'b0; k++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (outstanding !== 4'd0 || busy !== 1'b0) $display("FAIL slverr_drain: got out=%0d busy=%b want 0/0", outstanding, busy); else n_pass++;
      n_checks++; if (cmd_log.size() > n_at_err + 1) $display("FAIL slverr_no_new_cmd: got %0d want <=%0d", cmd_log.size(), n_at_err + 1); else n_pass++;
      n_checks++; if (blocks_done !== 32'd2 || err !== 1'b1 || err_sts !== 8'hC2) $display("FAIL slverr_frozen: got %0d/%b/%h want 2/1/c2", blocks_done, err, err_sts); else n_pass++;
   endtask

   task automatic test_tag_mismatch();
      int n_at_err;
      apply_reset();
      lat_min = 10; lat_max = 10;
      corrupt_idx = 2; corrupt_word = 8'h83;
      enable = 1'b1; cmd_tready = 1'b1;
      for (int k = 0; k < 200 && err !== 1'b1; k++) @(negedge clk);
      n_checks++; if (err !== 1'b1 || err_sts !== 8'h83 || blocks_done !== 32'd2) $display("FAIL tag_err: got %b/%h/%0d want 1/83/2", err, err_sts, blocks_done); else n_pass++;
      n_at_err = cmd_log.size();
      repeat (60) @(negedge clk);
      n_checks++; if (err !== 1'b1 || cmd_log.size() > n_at_err + 1) $display("FAIL tag_halt_persists: got err=%b cmds=%0d want 1/<=%0d", err, cmd_log.size(), n_at_err + 1); else n_pass++;
      apply_reset();
      @(negedge clk);
      n_checks++; if (err !== 1'b0 || wr_ptr !== BASE || outstanding !== 4'd0) $display("FAIL tag_reset_clear: got %b/%h/%0d want 0/%h/0", err, wr_ptr, outstanding, BASE); else n_pass++;
      enable = 1'b1; cmd_tready = 1'b1;
      for (int k = 0; k < 20 && cmd_log.size() < 1; k++) @(negedge clk);
      @(posedge clk);
      #1;
      enable = 1'b0;
      n_checks++; if (cmd_log.size() < 1 || cmd_log[0] !== exp_cmd(0)) $display("FAIL tag_restart_cmd: got %h want %h", (cmd_log.size() > 0) ? cmd_log[0] : 72'h0, exp_cmd(0)); else n_pass++;
      for (int k = 0; k < 60 && busy !== 1'b0; k++) @(negedge clk);
   endtask

   task automatic test_same_cycle_and_spurious();
      apply_reset();
      auto_sts = 1'b0;
      enable = 1'b1; cmd_tready = 1'b0;
      repeat (2) begin
         for (int k = 0; k < 20 && cmd_tvalid !== 1'b1; k++) @(negedge clk);
         @(posedge clk);
         #1;
         cmd_tready = 1'b1;
         @(posedge clk);
         #1;
         cmd_tready = 1'b0;
      end
      for (int k = 0; k < 20 && cmd_tvalid !== 1'b1; k++) @(negedge clk);
      n_checks++; if (outstanding !== 4'd2 || cmd_tvalid !== 1'b1) $display("FAIL sim_pre: got out=%0d tvalid=%b want 2/1", outstanding, cmd_tvalid); else n_pass++;
      force_word = 8'h80; force_seq++;
      @(posedge clk);
      #1;
      cmd_tready = 1'b1; enable = 1'b0;
      @(negedge clk);
      n_checks++; if (!(cmd_tvalid && sts_tvalid && sts_tready)) $display("FAIL sim_both_valid: got %b/%b/%b want 1/1/1", cmd_tvalid, sts_tvalid, sts_tready); else n_pass++;
      @(posedge clk);
      #1;
      cmd_tready = 1'b0;
      @(negedge clk);
      n_checks++; if (outstanding !== 4'd2 || blocks_done !== 32'd1) $display("FAIL sim_outstanding: got %0d/%0d want 2/1", outstanding, blocks_done); else n_pass++;
      force_word = 8'h81; force_seq++;
      repeat (3) @(negedge clk);
      force_word = 8'h82; force_seq++;
      repeat (3) @(negedge clk);
      n_checks++; if (outstanding !== 4'd0 || blocks_done !== 32'd3 || busy !== 1'b0 || err !== 1'b0 || wr_ptr !== exp_ptr(3)) $display("FAIL sim_drained: got out=%0d done=%0d busy=%b err=%b ptr=%h want 0/3/0/0/%h", outstanding, blocks_done, busy, err, wr_ptr, exp_ptr(3)); else n_pass++;
      force_word = 8'h83; force_seq++;
      repeat (3) @(negedge clk);
      n_checks++; if (err !== 1'b1 || err_sts !== 8'h83 || outstanding !== 4'd0) $display("FAIL spurious_sts: got err=%b sts=%h out=%0d want 1/83/0", err, err_sts, outstanding); else n_pass++;
   endtask

   task automatic test_random();
      int n;
      apply_reset();
      lat_min = 1; lat_max = 30;
      enable = 1'b1; cmd_tready = 1'b1;
      repeat (400) begin
         @(posedge clk);
         #1;
         cmd_tready = ($urandom_range(3, 0) != 0);
         enable     = ($urandom_range(9, 0) != 0);
      end
      enable = 1'b0; cmd_tready = 1'b1;
      for (int k = 0; k < 300 && busy !== 1'b0; k++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      n = cmd_log.size();
      n_checks++; if (busy !== 1'b0 || n < 20) $display("FAIL rand_drain: got busy=%b cmds=%0d want 0/>=20", busy, n); else n_pass++;
      for (int i = 0; i < n; i++) begin
         n_checks++; if (cmd_log[i] !== exp_cmd(i)) $display("FAIL rand_cmd%0d: got %h want %h", i, cmd_log[i], exp_cmd(i)); else n_pass++;
      end
      n_checks++; if (blocks_done !== 32'(n) || wr_ptr !== exp_ptr(n) || err !== 1'b0) $display("FAIL rand_done: got %0d/%h/%b want %0d/%h/0", blocks_done, wr_ptr, err, n, exp_ptr(n)); else n_pass++;
      n_checks++; if (max_out > 4'd4) $display("FAIL rand_max_out: got %0d want <=4", max_out); else n_pass++;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      test_reset();
      test_stream_wrap();
      test_backpressure();
      test_slverr();
      test_tag_mismatch();
      test_same_cycle_and_spurious();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
